result_drain: RTL

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/result_drain.sv | 131 +++++++++++++
 1 files changed

// File: rtl/result_drain.sv
// Captures an accumulator matrix and drains it one requantized row per transfer.
// Each element is rounded, arithmetic-shifted and saturated on the way out.
`ifndef ARRAY_HEIGHT
`define ARRAY_HEIGHT 4
`endif
`ifndef ARRAY_WIDTH
`define ARRAY_WIDTH 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// state | meaning
// IDLE  | no matrix held, waiting for result_valid
// DRAIN | presenting row row_idx of the captured matrix
module result_drain #(
   parameter int ROWS  = `ARRAY_HEIGHT,
   parameter int COLS  = `ARRAY_WIDTH,
   parameter int ACC_W = `ACC_WIDTH,
   parameter int OUT_W = `DATA_WIDTH,
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic signed [ROWS-1:0][COLS-1:0][ACC_W-1:0] results,
   input  logic                                        result_valid,
   input  logic        [4:0]                           shift,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic signed [COLS-1:0][OUT_W-1:0]           out_data,
   output logic        [RW-1:0]                        out_row,
   output logic                                        out_last,
   output logic                                        busy,
   output logic                                        overrun,
   output logic                                        drain_done
);

   typedef enum logic {IDLE, DRAIN} state_t;

   localparam logic [RW-1:0] LAST = RW'(ROWS - 1);
   localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W:0] QMIN = -QMAX - (ACC_W+1)'(1);

   state_t state, state_n;
   logic [RW-1:0] row_idx, row_n;
   logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] mat_q;
   logic [4:0] shift_q;
   logic overrun_q, drain_done_q;
   logic capture, final_xfer, ovr_set;

   always_comb begin
      state_n    = state;
      row_n      = row_idx;
      capture    = 1'b0;
      final_xfer = 1'b0;
      ovr_set    = 1'b0;
      case (state)
         IDLE: begin
            if (result_valid) begin
               capture = 1'b1;
               row_n   = '0;
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            final_xfer = out_ready && (row_idx == LAST);
            if (final_xfer) begin
               // a strobe landing on the final transfer starts the next matrix with no bubble
               row_n = '0;
               if (result_valid) capture = 1'b1;
               else state_n = IDLE;
            end else begin
               if (out_ready) row_n = row_idx + 1'b1;
               if (result_valid) ovr_set = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         row_idx      <= '0;
         overrun_q    <= 1'b0;
         drain_done_q <= 1'b0;
      end else begin
         state        <= state_n;
         row_idx      <= row_n;
         drain_done_q <= final_xfer;
         if (ovr_set) overrun_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         mat_q   <= results;
         shift_q <= shift;
      end
   end

   logic signed [ACC_W:0] rnd, v, sh;
   logic        [OUT_W-1:0] q;

   always_comb begin
      rnd      = (shift_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 5'd1));
      v        = '0;
      sh       = '0;
      q        = '0;
      out_data = '0;
      for (int c = 0; c < COLS; c++) begin
         v  = $signed({mat_q[row_idx][c][ACC_W-1], mat_q[row_idx][c]}) + rnd;
         sh = v >>> shift_q;
         if (sh > QMAX)      q = QMAX[OUT_W-1:0];
         else if (sh < QMIN) q = QMIN[OUT_W-1:0];
         else                q = sh[OUT_W-1:0];
         if (!rst) out_data[c] = q;
      end
   end

   assign out_valid  = (state == DRAIN) && !rst;
   assign busy       = out_valid;
   assign out_row    = rst ? '0 : row_idx;
   assign out_last   = !rst && (row_idx == LAST);
   assign overrun    = overrun_q && !rst;
   assign drain_done = drain_done_q && !rst;

endmodule
